// File: rtl/mips_trace_pkg.sv
// Shared types and width helpers for the MIPS trace capture unit.
// Holds the capture state enum and pointer/count width functions.
package mips_trace_pkg;

    typedef enum logic [1:0] {
        TR_IDLE  = 2'd0,
        TR_ARMED = 2'd1,
        TR_POST  = 2'd2,
        TR_DONE  = 2'd3
    } state_t;

    // Width of a buffer pointer / read index.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Width of a count that must reach depth itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int TR_DEF_DEPTH = 16;
    localparam int TR_DEF_PTR_W = ptr_w(TR_DEF_DEPTH);
    localparam int TR_DEF_CNT_W = cnt_w(TR_DEF_DEPTH);

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Probe, control, readback and status bundle of the trace buffer.
// master: core/debug-host side; slave: mips_trace_buffer.
interface mips_trace_buffer_if
    import mips_trace_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int DW = CHANNELS * WIDTH;

    logic          arm;
    logic          sample_valid;
    logic [DW-1:0] probe;
    logic          trig;
    logic [WIDTH-1:0] trig_pc;
    logic          rd_en;
    logic [PW-1:0] rd_idx;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [1:0]    state;
    logic          done;
    logic [CW-1:0] fill_count;
    logic [PW-1:0] trig_index;

    modport master (
        output arm, sample_valid, probe, trig, trig_pc,
        output rd_en, rd_idx,
        input  rd_data, rd_valid, state, done,
        input  fill_count, trig_index
    );

    modport slave (
        input  arm, sample_valid, probe, trig, trig_pc,
        input  rd_en, rd_idx,
        output rd_data, rd_valid, state, done,
        output fill_count, trig_index
    );

endinterface

// File: rtl/mips_trace_buffer_ram.sv
// trace_ram: simple dual-port sample store, one write per cycle,
// registered read (1-cycle latency) with a force-to-zero read option.
// Ports: clk, reset, we/waddr/wdata, re/rzero/raddr, rdata.
module trace_ram #(
    parameter int DW    = 128,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic          rzero,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register holds between reads.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= rzero ? '0 : mem[raddr];
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// Per-cycle trace capture: circular probe buffer frozen POST_TRIG
// samples after a trigger, read back oldest-first by a debug host.
// Ports: clk, reset (sync, active high), bus (mips_trace_buffer_if).
// Optional: define MIPS_TRACE_PC_MATCH_EN to also trigger when
// probe channel 0 (pc) equals trig_pc.
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic             clk,
    input  logic             reset,
    mips_trace_buffer_if.slave bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int DW = CHANNELS * WIDTH;

    state_t        state_q, state_n;
    logic [PW-1:0] wr_ptr_q, wr_ptr_n;
    logic [CW-1:0] fill_q, fill_n;
    logic [CW-1:0] post_q, post_n;
    logic          rd_valid_q;

    logic          hit;
    logic          we;
    logic          re;
    logic          rd_zero;
    logic [PW-1:0] oldest;
    logic [PW-1:0] rd_addr;

`ifdef MIPS_TRACE_PC_MATCH_EN
    logic pc_hit;
    assign pc_hit = (bus.probe[WIDTH-1:0] == bus.trig_pc);
    assign hit    = bus.sample_valid & (bus.trig | pc_hit);
`else
    logic unused_trig_pc;
    assign unused_trig_pc = ^bus.trig_pc;
    assign hit = bus.sample_valid & bus.trig;
`endif

    always_comb begin
        state_n  = state_q;
        wr_ptr_n = wr_ptr_q;
        fill_n   = fill_q;
        post_n   = post_q;
        we       = 1'b0;
        // arm takes priority over any write or trigger
        if (bus.arm) begin
            state_n  = TR_ARMED;
            wr_ptr_n = '0;
            fill_n   = '0;
        end else if (bus.sample_valid) begin
            unique case (state_q)
                TR_ARMED: begin
                    we = 1'b1;
                    if (hit) begin
                        post_n  = CW'(POST_TRIG);
                        state_n = (POST_TRIG > 0) ? TR_POST
                                                  : TR_DONE;
                    end
                end
                TR_POST: begin
                    we     = 1'b1;
                    post_n = post_q - 1'b1;
                    if (post_q == CW'(1)) state_n = TR_DONE;
                end
                default: ;
            endcase
            if (we) begin
                wr_ptr_n = wr_ptr_q + 1'b1;
                if (fill_q != CW'(DEPTH))
                    fill_n = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TR_IDLE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            post_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            wr_ptr_q   <= wr_ptr_n;
            fill_q     <= fill_n;
            post_q     <= post_n;
            rd_valid_q <= re;
        end
    end

    // Pointer math wraps mod DEPTH; a full buffer gives oldest=wr_ptr.
    assign oldest  = wr_ptr_q - PW'(fill_q);
    assign rd_addr = oldest + bus.rd_idx;
    assign rd_zero = (CW'(bus.rd_idx) >= fill_q);
    assign re      = bus.rd_en & (state_q == TR_DONE);

    trace_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (bus.probe),
        .re    (re),
        .rzero (rd_zero),
        .raddr (rd_addr),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid   = rd_valid_q;
    assign bus.state      = state_q;
    assign bus.done       = (state_q == TR_DONE);
    assign bus.fill_count = fill_q;
    assign bus.trig_index = (state_q == TR_DONE)
        ? PW'(fill_q - CW'(1) - CW'(POST_TRIG)) : '0;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer: directed scenarios
// followed by random traffic against a queue-based reference model.
module tb_mips_trace_buffer;
    import mips_trace_pkg::*;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 8;
`ifdef MIPS_TRACE_PC_MATCH_EN
    localparam int POST_TRIG = 0;
`else
    localparam int POST_TRIG = 2;
`endif
    localparam int DW = CHANNELS * WIDTH;
    localparam int PW = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_trace_buffer_if #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)
    ) bus ();

    mips_trace_buffer #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS),
        .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 armed, 2 post, 3 done.
    // hist holds the stored samples, oldest first.
    int            m_state = 0;
    int            m_post  = 0;
    logic [DW-1:0] hist[$];
    logic          exp_rv  = 1'b0;
    logic [DW-1:0] exp_rd  = '0;

    task automatic check(input string tag,
                         input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit pcm;
        bit hitv;
        @(posedge clk);
        if (reset) begin
            m_state = 0;
            m_post  = 0;
            hist.delete();
            exp_rv  = 1'b0;
            exp_rd  = '0;
        end else begin
            exp_rv = 1'b0;
            if (bus.rd_en && m_state == 3) begin
                exp_rv = 1'b1;
                exp_rd = (int'(bus.rd_idx) < hist.size())
                    ? hist[bus.rd_idx] : '0;
            end
`ifdef MIPS_TRACE_PC_MATCH_EN
            pcm = (bus.probe[WIDTH-1:0] == bus.trig_pc);
`else
            pcm = 1'b0;
`endif
            hitv = bus.sample_valid && (bus.trig || pcm);
            if (bus.arm) begin
                m_state = 1;
                hist.delete();
            end else if (bus.sample_valid &&
                         (m_state == 1 || m_state == 2)) begin
                hist.push_back(bus.probe);
                if (hist.size() > DEPTH)
                    void'(hist.pop_front());
                if (m_state == 1) begin
                    if (hitv) begin
                        m_post  = POST_TRIG;
                        m_state = (POST_TRIG > 0) ? 2 : 3;
                    end
                end else begin
                    m_post--;
                    if (m_post == 0) m_state = 3;
                end
            end
        end
        #1;
        check("state", bus.state, m_state);
        check("done", bus.done, m_state == 3);
        check("fill", bus.fill_count, hist.size());
        check("rd_valid", bus.rd_valid, exp_rv);
        check("rd_data", bus.rd_data, exp_rd);
        if (m_state == 3)
            check("trig_index", bus.trig_index,
                  (hist.size() - 1 - POST_TRIG) % DEPTH);
    endtask

    task automatic drv(input bit a, input bit v, input bit t,
                       input logic [WIDTH-1:0] pc0,
                       input bit re, input int ri);
        logic [DW-1:0] p;
        p = '0;
        for (int c = 1; c < CHANNELS; c++)
            p[c*WIDTH +: WIDTH] = $urandom();
        p[WIDTH-1:0] = pc0;
        bus.arm          = a;
        bus.sample_valid = v;
        bus.trig         = t;
        bus.probe        = p;
        bus.rd_en        = re;
        bus.rd_idx       = PW'(ri);
        tick();
    endtask

    task automatic smp(input logic [WIDTH-1:0] pc0,
                       input bit t);
        drv(1'b0, 1'b1, t, pc0, 1'b0, 0);
    endtask

    task automatic rd(input int idx);
        drv(1'b0, 1'b0, 1'b0, '0, 1'b1, idx);
    endtask

    task automatic arm_it();
        drv(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
    endtask

    task automatic basic();
        int f;
        smp(32'h00, 1'b0);
        smp(32'h04, 1'b0);
        smp(32'h08, 1'b1);
        smp(32'h0C, 1'b0);
        smp(32'h10, 1'b0);
        f = 3 + POST_TRIG;
        check("basic_done", bus.state, 3);
        check("basic_fill", bus.fill_count, f);
        check("basic_tidx", bus.trig_index, 2);
        for (int i = 0; i < 5; i++) begin
            rd(i);
            check("basic_rv", bus.rd_valid, 1);
            check("basic_ch0", bus.rd_data[WIDTH-1:0],
                  (i < f) ? 4 * i : 0);
        end
        rd(6);
        check("oob_rv", bus.rd_valid, 1);
        check("oob_data", bus.rd_data, 0);
    endtask

    initial begin
        int kend;
        logic [1:0]  pc_state;
        int          pc_fill;
        bus.arm = 0; bus.sample_valid = 0; bus.trig = 0;
        bus.probe = '0; bus.trig_pc = '0;
        bus.rd_en = 0; bus.rd_idx = '0;
        reset = 1'b1;

        tick();
        tick();
        check("rst_state", bus.state, 0);
        check("rst_done", bus.done, 0);
        check("rst_fill", bus.fill_count, 0);
        check("rst_rv", bus.rd_valid, 0);
        reset = 1'b0;
        rd(0);
        check("idle_rd_rv", bus.rd_valid, 0);

        arm_it();
        basic();

        arm_it();
        for (int k = 0; k < 20; k++)
            smp(WIDTH'(4 * k), k == 15);
        kend = 15 + POST_TRIG;
        check("wrap_fill", bus.fill_count, DEPTH);
        check("wrap_tidx", bus.trig_index,
              DEPTH - 1 - POST_TRIG);
        rd(0);
        check("wrap_i0", bus.rd_data[WIDTH-1:0],
              4 * (kend - 7));
        rd(5);
        check("wrap_i5", bus.rd_data[WIDTH-1:0],
              4 * (kend - 2));
        rd(7);
        check("wrap_i7", bus.rd_data[WIDTH-1:0], 4 * kend);

        arm_it();
        drv(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 0);
        check("q_nov_state", bus.state, 1);
        check("q_nov_fill", bus.fill_count, 0);
        smp(32'h44, 1'b0);
        drv(1'b1, 1'b1, 1'b1, 32'h48, 1'b0, 0);
        check("q_arm_state", bus.state, 1);
        check("q_arm_fill", bus.fill_count, 0);
        smp(32'h4C, 1'b1);
        for (int i = 0; i < POST_TRIG; i++) begin
            check("q_post_state", bus.state, 2);
            smp(32'h50, 1'b1);
        end
        check("q_post_done", bus.state, 3);

        arm_it();
        smp(32'h60, 1'b0);
        smp(32'h64, 1'b0);
        smp(32'h68, 1'b1);
        smp(32'h6C, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_state", bus.state, 0);
        check("mid_rst_fill", bus.fill_count, 0);
        arm_it();
        basic();

`ifdef MIPS_TRACE_PC_MATCH_EN
        pc_state = 2'd3;
        pc_fill  = 3;
`else
        pc_state = 2'd1;
        pc_fill  = 4;
`endif
        bus.trig_pc = 32'h20;
        arm_it();
        smp(32'h18, 1'b0);
        smp(32'h1C, 1'b0);
        smp(32'h20, 1'b0);
        smp(32'h24, 1'b0);
        check("pc_state", bus.state, pc_state);
        check("pc_fill", bus.fill_count, pc_fill);

        for (int n = 0; n < 600; n++) begin
            logic [WIDTH-1:0] pc;
            pc = ($urandom_range(7) == 0)
                ? bus.trig_pc : WIDTH'($urandom());
            reset = ($urandom_range(63) == 0);
            drv($urandom_range(15) == 0,
                $urandom_range(3) != 0,
                $urandom_range(7) == 0,
                pc,
                $urandom_range(1) == 1,
                $urandom_range(DEPTH - 1));
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
